uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-to-parallel UART receiver. It is the receive-side counterpart of uart_tx and runs on the same system clock.
- Accepts 8N1 frames (LSB first) on an asynchronous serial line.
- Delivers each byte on rx_buf with a one-cycle done strobe. Flags framing errors.
- Sits between the board RX pin and the byte consumer (command parser / FIFO). Used in loopback with uart_tx for bring-up.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200). Legal minimum is 4.
- SYNC_STAGES, 2, number of input synchronizer flops (2 or 3).

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion takes effect immediately. Deassertion is synchronous to clk.
- enable  input  1  gates start-bit detection only. A frame already in progress always completes.
- serial_in  input  1  asynchronous serial line; idles high.
- rx_buf  output  8  last correctly received byte. Registered.
- done  output  1  one-cycle pulse when rx_buf is updated.
- frame_err  output  1  sticky framing-error flag. Cleared by the next good frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0):
  - state=IDLE.
  - rx_buf=8'h00; done=0; frame_err=0; busy=0.
  - Synchronizer flops preset to 1; bit counter and clock counter cleared.
- Synchronizer: serial_in passes through SYNC_STAGES flops to give serial_s. All decisions use serial_s only.
- IDLE:
  - If enable=1 and serial_s=0, go to START with cnt=0.
  - Otherwise stay in IDLE.
- START:
  - cnt counts up. At cnt=CLKS_PER_BIT/2-1 (integer divide), sample serial_s.
  - If the sample is 0: go to DATA with cnt=0 and bit_idx=0.
  - If the sample is 1: treat it as a glitch and return to IDLE. No outputs change.
- DATA:
  - At cnt=CLKS_PER_BIT-1, sample serial_s into shift[bit_idx], reset cnt=0, and increment bit_idx. Sampling is mid-bit.
  - After bit_idx=7 is sampled, go to STOP.
- STOP: at cnt=CLKS_PER_BIT-1, sample serial_s.
  - If 1: rx_buf<=shift, done=1 for exactly one cycle, frame_err<=0, then IDLE.
  - If 0: frame_err<=1, rx_buf unchanged, no done, then BREAK.
- BREAK: wait for serial_s=1, then go to IDLE. This stops a held-low line from re-triggering a start.
- Latency: done asserts at mid-stop-bit. That is SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the falling start edge at serial_in.
- Back-to-back frames: a start edge is detected from IDLE in the cycle after done. A 1-bit stop with no idle gap must be received loss-free.
- done is never asserted during reset or in the cycle reset deasserts.
- enable dropped mid-frame: the frame completes normally, and no new start is detected until enable=1.
- Reset mid-frame: the frame is aborted. The next frame after reset deasserts and the line idles is received correctly.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Adds output parity_err (1 bit, reset 0).
  - Adds a PARITY state between DATA and STOP that samples one extra bit at mid-bit.
  - Even parity is expected: XOR of the data bits equals the parity bit.
  - On mismatch, parity_err is set in the cycle done is asserted. rx_buf is still updated and done still pulses.
  - A good-parity frame clears parity_err.
  - Framing-error handling is unchanged.
- When undefined: the port and the state are absent, and the frame is plain 8N1.

Test Plan:
- CLKS_PER_BIT=8, frame model drives 0x13 -> exactly one done pulse; rx_buf=8'h13; frame_err=0; busy low after the stop sample.
- Back-to-back 0x37 then 0x00, 1-bit stops, no gap -> two done pulses, about 80 cycles apart; rx_buf=8'h37, then 8'h00.
- serial_in low for 2 cycles then high (CLKS_PER_BIT=8) -> START aborts to IDLE; no done; rx_buf unchanged.
- 0xA5 with stop bit driven 0, then line held low for 30 cycles, then high, then a good 0x5A -> frame_err=1 with no done and rx_buf holding the previous value; then done, rx_buf=8'h5A, frame_err=0.
- reset pulled low during DATA bit 4 -> rx_buf=0, busy=0, done=0 immediately; after release, an idle line and frame 0xC3 give rx_buf=8'hC3.
- UART_RX_PARITY_EN, frame 0x01 with parity bit 0 -> done=1, rx_buf=8'h01, parity_err=1; then 0x03 with parity bit 0 -> parity_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error detection and line-break hold-off.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       serial_in,
    output logic [7:0] rx_buf,
    output logic       done,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   serial_s;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [2:0]             bit_idx_reg, bit_idx_next;
    logic [7:0]             shift_reg, shift_next;
    logic [7:0]             rx_buf_reg, rx_buf_next;
    logic                   done_reg, done_next;
    logic                   frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                   parity_bit_reg, parity_bit_next;
    logic                   parity_err_reg, parity_err_next;
`endif

    // Presetting to 1 keeps an idle-high line from looking like a start bit after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], serial_in};
        end
    end

    assign serial_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            rx_buf_reg     <= '0;
            done_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            rx_buf_reg     <= rx_buf_next;
            done_reg       <= done_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        rx_buf_next     = rx_buf_reg;
        done_next       = 1'b0;
        frame_err_next  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = parity_err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (enable && !serial_s) begin
                    state_next = S_START;
                    cnt_next   = '0;
                end
            end
            S_START: begin
                if (cnt_reg == HALF_END) begin
                    cnt_next = '0;
                    if (!serial_s) begin
                        state_next   = S_DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_reg == BIT_END) begin
                    // LSB arrives first, so shifting in from the top leaves bit 0 at the bottom.
                    shift_next   = {serial_s, shift_reg[7:1]};
                    cnt_next     = '0;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_reg == BIT_END) begin
                    parity_bit_next = serial_s;
                    cnt_next        = '0;
                    state_next      = S_STOP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_reg == BIT_END) begin
                    cnt_next = '0;
                    if (serial_s) begin
                        rx_buf_next     = shift_reg;
                        done_next       = 1'b1;
                        frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        parity_err_next = (^shift_reg) != parity_bit_reg;
`endif
                        state_next      = S_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_BREAK: begin
                if (serial_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign rx_buf     = rx_buf_reg;
    assign done       = done_reg;
    assign frame_err  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`endif
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are built bit by bit from the byte value and the
// expected byte stream is held in a queue that the done monitor consumes.
module tb_uart_rx;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       serial_in;
    logic [7:0] rx_buf;
    logic       done;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic       perr_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_done = 1'b0;

    uart_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .serial_in (serial_in),
        .rx_buf    (rx_buf),
        .done      (done),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    // One complete frame; expect_rx says whether the receiver should accept it.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic bad_par, input logic expect_rx);
        if (expect_rx && stop_bit) begin
            exp_q.push_back(data);
            perr_q.push_back(bad_par);
            last_good = data;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^data) ^ bad_par);
`endif
        drive_bit(stop_bit);
    endtask

    // Scoreboard: every done must match the next expected byte.
    always @(negedge clk) begin
        if (done) begin
            check("done_single", {31'd0, prev_done}, 0);
            check("done_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                logic       pe;
                e  = exp_q.pop_front();
                pe = perr_q.pop_front();
                $display("rx byte got=%02h exp=%02h", rx_buf, e);
                check("rx_buf", {24'd0, rx_buf}, {24'd0, e});
                check("frame_err_clr", {31'd0, frame_err}, 0);
`ifdef UART_RX_PARITY_EN
                check("parity_err", {31'd0, parity_err}, {31'd0, pe});
`else
                if (pe) $display("note: parity flag ignored in 8N1 build");
`endif
            end
        end
        prev_done = done;
    end

    initial begin
        logic [7:0] b;
        reset     = 1'b0;
        enable    = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_buf", {24'd0, rx_buf}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        reset = 1'b1;
        idle(5);

        // Single frame
        send_frame(8'h13, 1'b1, 1'b0, 1'b1);
        idle(1);
        check("busy_after_stop", {31'd0, busy}, 0);
        check("rx_13", {24'd0, rx_buf}, 8'h13);
        idle(4);

        // Back-to-back, no idle gap
        send_frame(8'h37, 1'b1, 1'b0, 1'b1);
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("rx_b2b", {24'd0, rx_buf}, 8'h00);

        // Short glitch is rejected
        serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(12);
        check("glitch_busy", {31'd0, busy}, 0);
        check("glitch_rx", {24'd0, rx_buf}, {24'd0, last_good});

        // Framing error, held-low break, then recovery
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        serial_in = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("fe_set", {31'd0, frame_err}, 1);
        check("fe_busy_break", {31'd0, busy}, 1);
        check("fe_rx_hold", {24'd0, rx_buf}, {24'd0, last_good});
        idle(6);
        check("break_released", {31'd0, busy}, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("fe_cleared", {31'd0, frame_err}, 0);
        check("rx_5a", {24'd0, rx_buf}, 8'h5A);

        // Reset in the middle of data bit 4
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_rx_buf", {24'd0, rx_buf}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        last_good = 8'h00;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(10);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("rx_c3", {24'd0, rx_buf}, 8'hC3);

        // Enable dropped mid-frame: frame completes, next frame is ignored
        fork
            send_frame(8'h6E, 1'b1, 1'b0, 1'b1);
            begin
                repeat (30) @(posedge clk);
                #1;
                enable = 1'b0;
            end
        join
        idle(2);
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        idle(4);
        check("en_off_rx", {24'd0, rx_buf}, 8'h6E);
        check("en_off_busy", {31'd0, busy}, 0);
        enable = 1'b1;
        idle(2);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        idle(3);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        idle(3);
`endif

        // Randomized traffic with random gaps and occasional glitches
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                idle(2);
                serial_in = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
                idle(12);
            end else begin
                idle($urandom_range(0, 3));
            end
        end

        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
        check("final_rx", {24'd0, rx_buf}, {24'd0, last_good});
        check("final_fe", {31'd0, frame_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
